// File: rtl/io_pulse_pkg.sv
// Shared constants for the io_pulse_counter_wb register block: word offsets, CTRL bit
// positions, parameter limits and the Wishbone handshake states.
package io_pulse_pkg;

   localparam int unsigned OFS_CTRL   = 0;
   localparam int unsigned OFS_STATUS = 1;
   localparam int unsigned OFS_COUNT0 = 2;

   localparam int unsigned IRQ_EN_BIT = 8;

   localparam int unsigned NCH_MAX = 8;
   localparam int unsigned CW_MAX  = 32;

   typedef enum logic {
      StIdle,
      StAck
   } wb_state_e;

endpackage

// File: rtl/io_edge_sync.sv
// Two-flop synchronizer for one asynchronous pad input, followed by a delay flop whose
// comparison with the synchronized level yields a one-cycle rising-edge strobe.
module io_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= din;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/io_pulse_counter_wb.sv
// Per-channel rising-edge counters on user pad inputs, read and cleared over a Wishbone
// classic slave, with sticky wrap flags feeding a registered level interrupt.
module io_pulse_counter_wb
   import io_pulse_pkg::*;
#(
   parameter int unsigned NCH      = 4,
   parameter int unsigned CW       = 16,
   parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
   input  logic           wb_clk_i,
   input  logic           wb_rst_i,
   input  logic           wbs_cyc_i,
   input  logic           wbs_stb_i,
   input  logic           wbs_we_i,
   input  logic [3:0]     wbs_sel_i,
   input  logic [31:0]    wbs_adr_i,
   input  logic [31:0]    wbs_dat_i,
   output logic           wbs_ack_o,
   output logic [31:0]    wbs_dat_o,
   input  logic [NCH-1:0] io_in,
   output logic           irq
);

   if (NCH < 1 || NCH > NCH_MAX || CW < 1 || CW > CW_MAX) begin : g_bad_param
      $error("io_pulse_counter_wb: NCH or CW out of range");
   end

   wb_state_e      state_q, state_d;
   logic [31:0]    dat_q;
   logic [31:0]    rdata;
   logic [NCH-1:0] en_q, en_d;
   logic [NCH-1:0] ovf_q, ovf_d;
   logic [NCH-1:0] rise;
   logic           irq_en_q, irq_en_d;
   logic           irq_q;
   logic [CW-1:0]  count_q [NCH];
   logic [CW-1:0]  count_d [NCH];
   logic [5:0]     ofs;
   logic           req;
   logic           hit;
   logic           wr;
   logic           unused_bits;

   // Byte lanes, the low address bits and unmapped data bits carry no meaning here.
   assign unused_bits = ^{wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i};

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      io_edge_sync u_sync (
         .clk  (wb_clk_i),
         .rst  (wb_rst_i),
         .din  (io_in[i]),
         .rise (rise[i])
      );
   end

   assign ofs = wbs_adr_i[7:2];
   assign req = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
   assign hit = (wbs_adr_i[31:8] == BASE_ADR[31:8]) && (32'(ofs) < OFS_COUNT0 + NCH);
   assign wr  = req & wbs_we_i & hit;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (wbs_cyc_i && wbs_stb_i) state_d = StAck;
         StAck:  state_d = StIdle;
      endcase
   end

   always_comb begin
      rdata = '0;
      if (hit) begin
         if (ofs == 6'(OFS_CTRL)) begin
            rdata[NCH-1:0]    = en_q;
            rdata[IRQ_EN_BIT] = irq_en_q;
         end else if (ofs == 6'(OFS_STATUS)) begin
            rdata[NCH-1:0] = ovf_q;
         end
         for (int i = 0; i < NCH; i++) begin
            if (ofs == 6'(OFS_COUNT0 + i)) rdata[CW-1:0] = count_q[i];
         end
      end
   end

   // Clear beats a coincident edge; a new wrap beats a coincident W1C.
   always_comb begin
      en_d     = en_q;
      irq_en_d = irq_en_q;
      ovf_d    = ovf_q;
      count_d  = count_q;
      if (wr && ofs == 6'(OFS_CTRL)) begin
         en_d     = wbs_dat_i[NCH-1:0];
         irq_en_d = wbs_dat_i[IRQ_EN_BIT];
      end
      if (wr && ofs == 6'(OFS_STATUS)) ovf_d = ovf_q & ~wbs_dat_i[NCH-1:0];
      for (int i = 0; i < NCH; i++) begin
         if (wr && ofs == 6'(OFS_COUNT0 + i)) begin
            count_d[i] = '0;
         end else if (rise[i] && en_q[i]) begin
            count_d[i] = count_q[i] + CW'(1);
            if (&count_q[i]) ovf_d[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q  <= StIdle;
         dat_q    <= '0;
         en_q     <= '0;
         irq_en_q <= 1'b0;
         ovf_q    <= '0;
         irq_q    <= 1'b0;
         for (int i = 0; i < NCH; i++) count_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         dat_q    <= req ? rdata : '0;
         en_q     <= en_d;
         irq_en_q <= irq_en_d;
         ovf_q    <= ovf_d;
         irq_q    <= irq_en_q & (|ovf_q);
         for (int i = 0; i < NCH; i++) count_q[i] <= count_d[i];
      end
   end

   assign wbs_ack_o = (state_q == StAck);
   assign wbs_dat_o = dat_q;
   assign irq       = irq_q;

endmodule
